// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - arbitration mode encodings shared by the arbitrated mux and its arbiter
package mux_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_PRIO   = 2'b01,
        MODE_RR     = 2'b10,
        MODE_NONE   = 2'b11
    } mode_e;

    // Distance from ptr to idx walking upward with wrap, used to rank round-robin requests.
    function automatic int unsigned rr_distance(int unsigned idx, int unsigned ptr, int unsigned n);
        return (idx >= ptr) ? (idx - ptr) : (idx + n - ptr);
    endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// rtl/rr_arb_mux_if.sv - channel inputs, arbitration controls and output stream of rr_arb_mux
interface rr_arb_mux_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [1:0]                mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_ready;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational one-hot grant for static, fixed-priority and round-robin modes
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [1:0]          mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic [SEL_W-1:0]    ptr,
    output logic [CHANNELS-1:0] grant,
    output logic [SEL_W-1:0]    grant_idx
);

    int unsigned best_dist;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        best_dist = CHANNELS;
        case (mode)
            MODE_STATIC: begin
                // An out-of-range sel (non power-of-two CHANNELS) matches no channel.
                for (int i = 0; i < CHANNELS; i++) begin
                    if ((int'(sel) == i) && req[i]) begin
                        grant[i]  = 1'b1;
                        grant_idx = SEL_W'(i);
                    end
                end
            end
            MODE_PRIO: begin
                for (int i = CHANNELS - 1; i >= 0; i--) begin
                    if (req[i]) begin
                        grant     = '0;
                        grant[i]  = 1'b1;
                        grant_idx = SEL_W'(i);
                    end
                end
            end
            MODE_RR: begin
                // Nearest requester at or after ptr wins.
                for (int i = 0; i < CHANNELS; i++) begin
                    if (req[i] && (rr_distance(i, int'(ptr), CHANNELS) < best_dist)) begin
                        best_dist = rr_distance(i, int'(ptr), CHANNELS);
                        grant     = '0;
                        grant[i]  = 1'b1;
                        grant_idx = SEL_W'(i);
                    end
                end
            end
            MODE_NONE: begin
                grant = '0;
            end
        endcase
    end

endmodule

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-channel registered mux with valid/ready handshake and selectable arbitration
module rr_arb_mux
    import mux_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arb_mux_if.slave   bus
);

    localparam int SEL_W = $clog2(CHANNELS);

    logic                out_valid_q;
    logic [WIDTH-1:0]    out_data_q;
    logic [SEL_W-1:0]    out_chan_q;
    logic [SEL_W-1:0]    rr_ptr;

    logic                load_en;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    grant_idx;
    logic [CHANNELS-1:0] in_ready_c;
    logic                fire;
    logic [WIDTH-1:0]    sel_data;
    logic [SEL_W-1:0]    ptr_next;

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arbiter (
        .req       (bus.in_valid),
        .mode      (bus.mode),
        .sel       (bus.sel),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign load_en    = !out_valid_q || bus.out_ready;
    // Gating with rst_n keeps any producer from seeing a completed transfer during reset.
    assign in_ready_c = grant & {CHANNELS{load_en && rst_n}};
    assign fire       = |in_ready_c;
    assign ptr_next   = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_ptr      <= '0;
        end else if (fire) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_chan_q  <= grant_idx;
            if (bus.mode == MODE_RR) begin
                rr_ptr <= ptr_next;
            end
        end else if (load_en) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - directed and randomized checks of rr_arb_mux against a behavioural model
module tb_rr_arb_mux;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_arb_mux_if #(.WIDTH(4), .CHANNELS(4)) bus ();
    rr_arb_mux_if #(.WIDTH(4), .CHANNELS(3)) bus3 ();

    rr_arb_mux #(.WIDTH(4), .CHANNELS(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    rr_arb_mux #(.WIDTH(4), .CHANNELS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    int checks = 0;
    int errors = 0;

    bit m_valid;
    int m_data;
    int m_chan;
    int m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Winning channel under the arbitration rules, or -1 when nothing is granted.
    function automatic int ref_grant(input int mode, input int sel, input int valid, input int ptr, input int n);
        int c;
        case (mode)
            0: return (sel < n && valid[sel]) ? sel : -1;
            1: begin
                for (int i = 0; i < n; i++) if (valid[i]) return i;
                return -1;
            end
            2: begin
                for (int k = 0; k < n; k++) begin
                    c = (ptr + k) % n;
                    if (valid[c]) return c;
                end
                return -1;
            end
            default: return -1;
        endcase
    endfunction

    // One clock: compare at the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        int g;
        logic [3:0] er;
        bit rs, rdy;
        int md;
        logic [15:0] dat;
        @(negedge clk);
        rs  = rst_n;
        rdy = bus.out_ready;
        md  = int'(bus.mode);
        dat = bus.in_data;
        g   = ref_grant(md, int'(bus.sel), int'(bus.in_valid), m_ptr, 4);
        er  = (rs && (!m_valid || rdy) && g >= 0) ? 4'(1 << g) : 4'b0;
        chk("in_ready", 32'(bus.in_ready), 32'(er));
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("out_data", 32'(bus.out_data), 32'(m_data));
        chk("out_chan", 32'(bus.out_chan), 32'(m_chan));
        @(posedge clk);
        if (!rs) begin
            m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0;
        end else if (er != 0) begin
            m_valid = 1;
            m_data  = int'(dat[g*4 +: 4]);
            m_chan  = g;
            if (md == 2) m_ptr = (g + 1) % 4;
        end else if (!m_valid || rdy) begin
            m_valid = 0;
        end
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.mode      = 2'b01;
        bus.sel       = '0;
        bus.in_valid  = 4'hF;
        bus.in_data   = 16'h4321;
        bus.out_ready = 1'b1;
        bus3.mode     = 2'b00;
        bus3.sel      = '0;
        bus3.in_valid = 3'b111;
        bus3.in_data  = 12'h321;
        bus3.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data", 32'(bus.out_data), 32'h0);
        chk("rst_out_chan", 32'(bus.out_chan), 32'h0);
        chk("rst_rr_ptr", 32'(dut.rr_ptr), 32'h0);
        m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0;

        // Three-channel instance: sel beyond the last channel grants nothing.
        bus.in_valid = 4'h0;
        bus.mode     = 2'b00;
        rst_n        = 1'b1;
        @(posedge clk); #1;
        chk("c3_load_valid", 32'(bus3.out_valid), 32'h1);
        chk("c3_load_data", 32'(bus3.out_data), 32'h1);
        bus3.sel = 2'd3;
        #1;
        chk("c3_sel3_in_ready", 32'(bus3.in_ready), 32'h0);
        @(posedge clk); #1;
        chk("c3_sel3_drop", 32'(bus3.out_valid), 32'h0);
        chk("c3_sel3_hold_data", 32'(bus3.out_data), 32'h1);

        // Static sweep.
        bus.in_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            bus.sel = 2'(k);
            cycle();
            chk("static_data", 32'(bus.out_data), 32'(k + 1));
            chk("static_chan", 32'(bus.out_chan), 32'(k));
        end

        // Fixed priority starves ch3.
        bus.mode     = 2'b01;
        bus.in_valid = 4'b1010;
        repeat (4) begin
            cycle();
            chk("prio_chan", 32'(bus.out_chan), 32'h1);
        end

        // Round-robin from a fresh pointer.
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        bus.mode     = 2'b10;
        bus.in_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rr_all_chan", 32'(bus.out_chan), 32'(i % 4));
        end
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        bus.in_valid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rr_1001_chan", 32'(bus.out_chan), (i % 2) ? 32'h3 : 32'h0);
        end

        // Back-pressure then simultaneous consume and load.
        bus.mode     = 2'b01;
        bus.in_valid = 4'hF;
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        repeat (3) begin
            cycle();
            chk("stall_in_ready", 32'(bus.in_ready), 32'h0);
            chk("stall_data", 32'(bus.out_data), 32'h1);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b0100;
        cycle();
        chk("bp_release_valid", 32'(bus.out_valid), 32'h1);
        chk("bp_release_data", 32'(bus.out_data), 32'h3);
        chk("bp_release_chan", 32'(bus.out_chan), 32'h2);

        // Reset while stalled on 4'h3.
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'hF;
        bus.mode      = 2'b10;
        cycle();
        chk("mid_stall_data", 32'(bus.out_data), 32'h3);
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("mid_rst_data", 32'(bus.out_data), 32'h0);
        chk("mid_rst_ptr", 32'(dut.rr_ptr), 32'h0);
        bus.out_ready = 1'b1;
        cycle();
        chk("post_rst_rr_chan", 32'(bus.out_chan), 32'h0);

        // Reserved mode drains and grants nothing.
        bus.mode = 2'b11;
        cycle();
        chk("none_in_ready", 32'(bus.in_ready), 32'h0);
        chk("none_out_valid", 32'(bus.out_valid), 32'h0);

        // Randomized traffic including occasional reset.
        for (int n = 0; n < 400; n++) begin
            bus.mode      = 2'($urandom);
            bus.sel       = 2'($urandom);
            bus.in_valid  = 4'($urandom);
            bus.in_data   = 16'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst_n         = ($urandom_range(0, 39) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
